// File: rtl/wr_ddr_fifo_pack.sv
// Write-side DDR staging buffer: packs RATIO narrow words into one wide word and
// queues the wide words in a first-word-fall-through FIFO (RAM plus output register).
module wr_ddr_fifo_pack #(
    parameter int IN_WIDTH    = 64,
    parameter int RATIO       = 4,
    parameter int DEPTH_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    output logic                      wr_vld,
    input  logic [IN_WIDTH-1:0]       wr_data,
    input  logic                      flush,
    input  logic                      rd_en,
    output logic                      rd_vld,
    output logic [IN_WIDTH*RATIO-1:0] rd_data,
    output logic [DEPTH_WIDTH:0]      level,
    output logic                      ovf
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int RAM_DEPTH = (2 ** DEPTH_WIDTH) - 1;
    localparam int CNT_W     = DEPTH_WIDTH + 2;

    localparam logic [LANE_W-1:0]      LANE_LAST = LANE_W'(RATIO - 1);
    localparam logic [DEPTH_WIDTH-1:0] PTR_LAST  = DEPTH_WIDTH'(RAM_DEPTH - 1);
    localparam logic [CNT_W-1:0]       FULL_L    = CNT_W'(2 ** DEPTH_WIDTH);

    // Handshakes: a narrow word is taken on wr_en && wr_vld; a wide word leaves on
    // rd_en && rd_vld. Both valids are registered and stable for the whole cycle.

    logic [LANE_W-1:0]      lane_q;
    logic [OUT_WIDTH-1:0]   pack_q;
    logic                   flush_pend;
    logic                   push_vld;
    logic [OUT_WIDTH-1:0]   push_data;
    logic [OUT_WIDTH-1:0]   mem [RAM_DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH-1:0] ram_cnt;

    logic                   accept;
    logic [OUT_WIDTH-1:0]   pack_next;
    logic                   lane_full;
    logic [LANE_W-1:0]      lane_after;
    logic                   flush_req;
    logic                   space;
    logic                   flush_work;
    logic                   flush_push;
    logic                   pack_push;
    logic                   flush_pend_n;

    logic                   pop;
    logic                   bypass;
    logic                   ram_wr;
    logic                   ram_rd;
    logic [DEPTH_WIDTH:0]   level_n;
    logic                   wr_vld_n;

    // Packer: the write lands first, then any flush acts on the result.
    always_comb begin
        accept    = wr_en && wr_vld;
        pack_next = pack_q;
        if (accept) begin
            pack_next[int'(lane_q)*IN_WIDTH +: IN_WIDTH] = wr_data;
        end
        lane_full    = accept && (lane_q == LANE_LAST);
        lane_after   = lane_full ? '0 : lane_q + LANE_W'(accept);
        flush_req    = flush || flush_pend;
        space        = ({1'b0, level} + CNT_W'(push_vld)) < FULL_L;
        flush_work   = flush_req && !lane_full && (lane_after != '0);
        flush_push   = flush_work && space;
        pack_push    = lane_full || flush_push;
        flush_pend_n = flush_work && !space;
    end

    // Popping the last stored word while a push commits hands the push straight
    // to the output register so rd_vld never drops.
    always_comb begin
        pop      = rd_en && rd_vld;
        bypass   = push_vld && pop && (ram_cnt == '0);
        ram_wr   = push_vld && !bypass;
        ram_rd   = (ram_cnt != '0) && (!rd_vld || pop);
        level_n  = level + (DEPTH_WIDTH+1)'(push_vld) - (DEPTH_WIDTH+1)'(pop);
        // Reserve room for the push just issued, so an accepted word is never lost.
        wr_vld_n = !flush_pend_n && ((CNT_W'(level_n) + CNT_W'(pack_push)) < FULL_L);
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q     <= '0;
            pack_q     <= '0;
            flush_pend <= 1'b0;
            push_vld   <= 1'b0;
            push_data  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            rd_vld     <= 1'b0;
            rd_data    <= '0;
            level      <= '0;
            wr_vld     <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            lane_q     <= pack_push ? '0 : lane_after;
            pack_q     <= pack_push ? '0 : pack_next;
            flush_pend <= flush_pend_n;
            push_vld   <= pack_push;
            if (pack_push) begin
                push_data <= pack_next;
            end

            if (ram_wr) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (ram_rd) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            ram_cnt <= ram_cnt + DEPTH_WIDTH'(ram_wr) - DEPTH_WIDTH'(ram_rd);

            if (bypass) begin
                rd_vld  <= 1'b1;
                rd_data <= push_data;
            end else if (ram_rd) begin
                rd_vld  <= 1'b1;
                rd_data <= mem[rd_ptr];
            end else if (pop) begin
                rd_vld  <= 1'b0;
            end

            level  <= level_n;
            wr_vld <= wr_vld_n;
            if (wr_en && !wr_vld) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
